activation_writeback: RTL and testbench

- Drains the registered SA_LENGTH-wide activated vector from the activation stage into the on-chip output buffer.
- Captures one full vector per handshake, then serializes it as NBEATS = SA_LENGTH/LANES memory write beats of LANES elements each.
- Beats go to consecutive addresses starting at a per-vector base address.
- Sits between the activation stage and the output/feature-map SRAM. It is the consumer end of the activation output interface.

---
 rtl/activation_writeback.sv | 98 +++++++++
 tb/tb_activation_writeback.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_writeback.sv
// Activation-to-output-buffer writeback: captures one activated vector per
// handshake and drains it as LANES-wide write beats to consecutive addresses.
module activation_writeback #(
  parameter int DATA_WIDTH = 11,
  parameter int SA_LENGTH  = 256,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] vec_in [SA_LENGTH],
  input  logic                         vec_valid,
  output logic                         vec_ready,
  input  logic        [ADDR_WIDTH-1:0] base_addr,
  output logic                         mem_wr_en,
  output logic        [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic signed [DATA_WIDTH-1:0] mem_wr_data [LANES],
  input  logic                         mem_wr_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int NBEATS = SA_LENGTH / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IDX_W  = (SA_LENGTH > 1) ? $clog2(SA_LENGTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                         state;
  logic        [BEAT_W-1:0]       beat;
  logic        [BEAT_W-1:0]       beat_nxt;
  logic        [ADDR_WIDTH-1:0]   addr_base;
  logic signed [DATA_WIDTH-1:0]   buffer    [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0]   next_data [LANES];
  logic                           handshake;
  logic                           transfer;

  // Gating with rst keeps a handshake from completing while reset is held.
  assign vec_ready = (state == IDLE) && !rst;
  assign handshake = vec_valid && vec_ready;
  assign transfer  = mem_wr_en && mem_wr_ready;
  assign busy      = (state == WRITE);

  // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    beat_nxt = beat + BEAT_W'(1);
    for (int k = 0; k < LANES; k++) begin
      next_data[k] = buffer[IDX_W'(int'(beat_nxt) * LANES + k)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      addr_base   <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      done        <= 1'b0;
      for (int k = 0; k < LANES; k++) mem_wr_data[k] <= '0;
      // NOTE: the capture buffer is cleared on reset so no stale vector survives an aborted transfer.
      for (int i = 0; i < SA_LENGTH; i++) buffer[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            buffer      <= vec_in;
            addr_base   <= base_addr;
            beat        <= '0;
            state       <= WRITE;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= base_addr;
            for (int k = 0; k < LANES; k++) mem_wr_data[k] <= vec_in[k];
          end
        end
        WRITE: begin
          // Outputs only advance on an accepted beat, so a stalled beat holds steady.
          if (transfer) begin
            if (beat == LAST_BEAT) begin
              state     <= IDLE;
              mem_wr_en <= 1'b0;
              done      <= 1'b1;
            end else begin
              beat        <= beat_nxt;
              mem_wr_addr <= addr_base + ADDR_WIDTH'(beat_nxt);
              mem_wr_data <= next_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_writeback.sv
// Self-checking bench for activation_writeback: table-driven vectors, hand-written
// corner sequences and randomized traffic against a queue-based write model.
module tb_activation_writeback;

  localparam int DW = 11;
  localparam int SA = 8;
  localparam int LN = 4;
  localparam int NB = SA / LN;
  localparam int AW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] vec_in [SA];
  logic                 vec_valid = 1'b0;
  logic                 vec_ready;
  logic        [AW-1:0] base_addr = '0;
  logic                 mem_wr_en;
  logic        [AW-1:0] mem_wr_addr;
  logic signed [DW-1:0] mem_wr_data [LN];
  logic                 mem_wr_ready = 1'b1;
  logic                 busy;
  logic                 done;

  // Second instance with a 4-bit address space to exercise silent wrap.
  logic        [3:0]    w_base;
  logic                 w_ready, w_en, w_busy, w_done;
  logic        [3:0]    w_addr;
  logic signed [DW-1:0] w_data [LN];

  assign w_base = base_addr[3:0];

  always #5 clk = ~clk;

  activation_writeback #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .LANES(LN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .vec_in(vec_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .base_addr(base_addr), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready), .busy(busy), .done(done)
  );

  activation_writeback #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .LANES(LN), .ADDR_WIDTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .vec_in(vec_in), .vec_valid(vec_valid), .vec_ready(w_ready),
    .base_addr(w_base), .mem_wr_en(w_en), .mem_wr_addr(w_addr),
    .mem_wr_data(w_data), .mem_wr_ready(mem_wr_ready), .busy(w_busy), .done(w_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LN*DW-1:0] pack(input logic signed [DW-1:0] a [LN]);
    logic [LN*DW-1:0] p;
    for (int k = 0; k < LN; k++) p[k*DW +: DW] = a[k];
    return p;
  endfunction

  // Reference model: every accepted vector becomes NB expected writes in order.
  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [LN*DW-1:0] data;
  } beat_t;

  beat_t sbq[$];
  bit    done_exp = 1'b0;
  bit    idle_m;
  int    cyc      = 0;
  int    n_writes = 0;
  int    hs_last  = 0;
  int    hs_prev  = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sbq.delete();
      done_exp = 1'b0;
      check("rst_ready", vec_ready, 0);
      check("rst_en", mem_wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wrap_en", w_en, 0);
    end else begin
      idle_m = (sbq.size() == 0);
      check("ready", vec_ready, idle_m);
      check("wrap_ready", w_ready, idle_m);
      check("en", mem_wr_en, !idle_m);
      check("wrap_en", w_en, !idle_m);
      check("busy", busy, !idle_m);
      check("wrap_busy", w_busy, !idle_m);
      check("done", done, done_exp);
      check("wrap_done", w_done, done_exp);
      done_exp = 1'b0;
      if (!idle_m) begin
        check("addr", mem_wr_addr, sbq[0].addr);
        check("wrap_addr", w_addr, sbq[0].addr[3:0]);
        check("data", pack(mem_wr_data), sbq[0].data);
        check("wrap_data", pack(w_data), sbq[0].data);
        if (mem_wr_ready) begin
          void'(sbq.pop_front());
          n_writes++;
          if (sbq.size() == 0) done_exp = 1'b1;
        end
      end
      if (vec_valid && idle_m) begin
        for (int b = 0; b < NB; b++) begin
          beat_t e;
          e.addr = base_addr + AW'(b);
          for (int k = 0; k < LN; k++) e.data[k*DW +: DW] = vec_in[b*LN + k];
          sbq.push_back(e);
        end
        hs_prev = hs_last;
        hs_last = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < SA; i++) vec_in[i] = DW'($urandom);
  endtask

  typedef enum {PAT_RAMP, PAT_NEG} pat_t;
  typedef struct {
    logic [AW-1:0] base;
    pat_t          pat;
    int            first;
    int            stall_beat;
    int            stall_len;
    int            exp_lat;
    int            exp_nr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int lat, nr, w0, waited;

    tbl[0] = '{16'h0010, PAT_RAMP,   0, 0, 0, 2, 2};
    tbl[1] = '{16'h0010, PAT_RAMP,   0, 1, 3, 5, 5};
    tbl[2] = '{16'h000F, PAT_RAMP, 100, 0, 0, 2, 2};
    tbl[3] = '{16'hFFFF, PAT_NEG,    0, 0, 2, 4, 4};
    tbl[4] = '{16'h1234, PAT_NEG,    0, 1, 1, 3, 3};

    for (int i = 0; i < SA; i++) vec_in[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("reset_en", mem_wr_en, 0);
    check("reset_addr", mem_wr_addr, 0);
    check("reset_data", pack(mem_wr_data), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", vec_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("ready_after_reset", vec_ready, 1);
    tick();

    // Table-driven vectors: latency to done and not-ready cycle count.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < SA; i++)
        vec_in[i] = (tbl[r].pat == PAT_RAMP) ? DW'(tbl[r].first + i)
                                             : ((i % 2 == 0) ? DW'(-1024) : DW'(-1));
      base_addr    = tbl[r].base;
      vec_valid    = 1'b1;
      mem_wr_ready = 1'b1;
      w0           = n_writes;
      tick();
      vec_valid = 1'b0;
      lat = -1;
      nr  = 0;
      for (int j = 0; j < 50; j++) begin
        rand_vec();
        mem_wr_ready = !(j >= tbl[r].stall_beat && j < tbl[r].stall_beat + tbl[r].stall_len);
        #1;
        if (done) begin
          lat = j;
          break;
        end
        if (!vec_ready) nr++;
        tick();
      end
      check($sformatf("row%0d_latency", r), lat, tbl[r].exp_lat);
      check($sformatf("row%0d_not_ready", r), nr, tbl[r].exp_nr);
      check($sformatf("row%0d_writes", r), n_writes - w0, NB);
      mem_wr_ready = 1'b1;
      tick();
    end

    // Back-to-back: valid held, second handshake lands in the done cycle.
    for (int i = 0; i < SA; i++) vec_in[i] = DW'(20 + i);
    base_addr = 16'h0030;
    vec_valid = 1'b1;
    tick();
    for (int i = 0; i < SA; i++) vec_in[i] = DW'(40 + i);
    base_addr = 16'h0020;
    tick();
    tick();
    #1;
    check("b2b_done", done, 1);
    check("b2b_ready_in_done", vec_ready, 1);
    tick();
    vec_valid = 1'b0;
    #1 check("b2b_second_addr", mem_wr_addr, 16'h0020);
    check("b2b_hs_spacing", hs_last - hs_prev, NB + 1);
    repeat (4) tick();

    // Async reset mid beat 0: outputs drop without a clock edge, nothing stale follows.
    for (int i = 0; i < SA; i++) vec_in[i] = DW'(60 + i);
    base_addr = 16'h0050;
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    check("pre_reset_en", mem_wr_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_en", mem_wr_en, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_ready", vec_ready, 0);
    check("async_addr", mem_wr_addr, 0);
    tick();
    tick();
    rst = 1'b0;
    w0  = n_writes;
    #1 check("post_reset_ready", vec_ready, 1);
    repeat (5) tick();
    check("no_stale_writes", n_writes - w0, 0);

    // Randomized traffic with random backpressure and gaps.
    for (int n = 0; n < 40; n++) begin
      rand_vec();
      base_addr = AW'($urandom);
      vec_valid = 1'b1;
      waited    = 0;
      while (1) begin
        mem_wr_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (vec_ready) begin
          tick();
          break;
        end
        tick();
        waited++;
        if (waited > 100) begin
          check("rand_handshake_timeout", waited, 0);
          break;
        end
      end
      vec_valid = 1'b0;
      rand_vec();
      repeat ($urandom_range(0, 2)) begin
        mem_wr_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    waited = 0;
    while (sbq.size() != 0 && waited < 200) begin
      mem_wr_ready = ($urandom_range(0, 1) != 0);
      tick();
      waited++;
    end
    mem_wr_ready = 1'b1;
    repeat (2) tick();
    check("drain_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
